// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter for the WM8731 DAC: one mono sample per frame, sent on both slots,
// with a single-entry holding register paced by valid/ready and underrun accounting.
module audio_dac_i2s_tx #(
  parameter int BCLK_HALF = 16,
  parameter int SAMPLE_W  = 16
) (
  input  logic                clk50_i,
  input  logic                restart_i,
  input  logic [SAMPLE_W-1:0] sample_in_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  output logic                aud_bclk_o,
  output logic                aud_daclrck_o,
  output logic                aud_dacdat_o,
  output logic                frame_load_o,
  output logic                underrun_o,
  output logic [15:0]         underrun_cnt_o
);

  localparam int FW = 2 * SAMPLE_W;
  localparam int BW = $clog2(FW);
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DW-1:0]       div_cnt_q;
  logic [BW-1:0]       bit_cnt_q;
  logic                bclk_q, lrck_q, dat_q;
  logic                hold_full_q, frame_load_q, underrun_q;
  logic [SAMPLE_W-1:0] hold_q;
  logic [FW-1:0]       shadow_q, shadow_d;
  logic [15:0]         ur_cnt_q;

  logic          wrap, fall, load, accept;
  logic [BW-1:0] bit_nxt, slot, sel;

  always_comb begin
    wrap     = (div_cnt_q == DW'(BCLK_HALF - 1));
    fall     = wrap & bclk_q;
    bit_nxt  = (bit_cnt_q == BW'(FW - 1)) ? '0 : bit_cnt_q + 1'b1;
    load     = fall & (bit_nxt == BW'(1));
    accept   = sample_valid_i & ~hold_full_q;
    shadow_d = shadow_q;
    if (load && hold_full_q) shadow_d = {hold_q, hold_q};
    // One-bit I2S delay: slot k carries shadow bit (k-1), so slot 0 is the previous LSB.
    slot = (bit_nxt == '0) ? BW'(FW - 1) : bit_nxt - 1'b1;
    sel  = BW'(FW - 1) - slot;
  end

  always_ff @(posedge clk50_i) begin
    if (restart_i) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      dat_q        <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_q       <= '0;
      shadow_q     <= '0;
      frame_load_q <= 1'b0;
      underrun_q   <= 1'b0;
      ur_cnt_q     <= '0;
    end else begin
      div_cnt_q <= wrap ? '0 : div_cnt_q + 1'b1;
      if (wrap) bclk_q <= ~bclk_q;
      if (fall) begin
        bit_cnt_q <= bit_nxt;
        lrck_q    <= (bit_nxt >= BW'(SAMPLE_W));
        dat_q     <= shadow_d[sel];
      end
      shadow_q     <= shadow_d;
      frame_load_q <= load;
      underrun_q   <= load & ~hold_full_q;
      if (load && !hold_full_q && ur_cnt_q != 16'hFFFF) ur_cnt_q <= ur_cnt_q + 16'd1;
      // A load empties the register before a new sample can be taken; accept needs it empty.
      if (load && hold_full_q) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_full_q <= 1'b1;
        hold_q      <= sample_in_i;
      end
    end
  end

  assign sample_ready_o = ~hold_full_q;
  assign aud_bclk_o     = bclk_q;
  assign aud_daclrck_o  = lrck_q;
  assign aud_dacdat_o   = dat_q;
  assign frame_load_o   = frame_load_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ur_cnt_q;

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Bench for audio_dac_i2s_tx: directed vector table, hand sequences for handshake corners,
// and random traffic against a time-based reference model.
module tb_audio_dac_i2s_tx;
  localparam int H = 16, W = 16, FR = 2 * H * 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vld;
  logic [15:0] din;
  logic        rdy, bclk, lrck, dat, fl, ur;
  logic [15:0] ucnt;

  audio_dac_i2s_tx #(.BCLK_HALF(H), .SAMPLE_W(W)) dut (
    .clk50_i(clk), .restart_i(rst), .sample_in_i(din), .sample_valid_i(vld),
    .sample_ready_o(rdy), .aud_bclk_o(bclk), .aud_daclrck_o(lrck), .aud_dacdat_o(dat),
    .frame_load_o(fl), .underrun_o(ur), .underrun_cnt_o(ucnt)
  );

  int tests = 0, fails = 0;

  // Reference state: n = edges since the last reset edge.
  int          n = 0;
  bit          m_full, m_fl, m_ur;
  logic [15:0] m_hold, m_word, m_cnt;
  logic        prev_bclk, prev_dat;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %h expected %h at n=%0d", name, act, exp, n);
    end
  endtask

  function automatic logic exp_dat();
    int f, k, p;
    logic [31:0] w;
    f = n / (2 * H);
    if (f == 0) return 1'b0;
    k = f % (2 * W);
    p = (k + 2 * W - 1) % (2 * W);
    w = {m_word, m_word};
    return w[2 * W - 1 - p];
  endfunction

  task automatic step();
    bit ld, pre_full;
    prev_bclk = bclk;
    prev_dat  = dat;
    @(posedge clk);
    if (rst) begin
      n = 0; m_full = 0; m_fl = 0; m_ur = 0; m_hold = '0; m_word = '0; m_cnt = '0;
    end else begin
      n++;
      ld       = (n % (2 * H) == 0) && ((n / (2 * H)) % (2 * W) == 1);
      pre_full = m_full;
      m_fl     = ld;
      m_ur     = ld && !pre_full;
      if (ld) begin
        if (pre_full) begin m_word = m_hold; m_full = 0; end
        else if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (vld && !pre_full) begin m_hold = din; m_full = 1; end
    end
    #1;
    check("model", {10'd0, rdy, bclk, lrck, dat, fl, ur, ucnt},
          {10'd0, !m_full, logic'((n / H) % 2), logic'(((n / (2 * H)) % (2 * W)) >= W),
           exp_dat(), m_fl, m_ur, m_cnt});
    if (!rst && prev_bclk === 1'b0 && bclk === 1'b1) check("dat_on_rise", dat, prev_dat);
  endtask

  task automatic run_to(int target);
    while (n < target) step();
  endtask

  typedef struct {
    bit rst; bit vld; logic [15:0] data; int cyc;
    bit e_rdy; bit e_bclk; bit e_lrck; bit e_dat; bit e_fl; bit e_ur; logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vld = 1'b0; din = '0;

    // One sample (0x5000) then starvation: n is the edge count after the row.
    tbl[0]  = '{1, 0, 16'h0000,   1, 1, 0, 0, 0, 0, 0, 16'd0}; // n=0
    tbl[1]  = '{0, 1, 16'h5000,   1, 0, 0, 0, 0, 0, 0, 16'd0}; // n=1 accepted
    tbl[2]  = '{0, 0, 16'h0000,  14, 0, 0, 0, 0, 0, 0, 16'd0}; // n=15
    tbl[3]  = '{0, 0, 16'h0000,   1, 0, 1, 0, 0, 0, 0, 16'd0}; // n=16 first rise
    tbl[4]  = '{0, 0, 16'h0000,  16, 1, 0, 0, 0, 1, 0, 16'd0}; // n=32 load, MSB
    tbl[5]  = '{0, 0, 16'h0000,   1, 1, 0, 0, 0, 0, 0, 16'd0}; // n=33
    tbl[6]  = '{0, 0, 16'h0000,  31, 1, 0, 0, 1, 0, 0, 16'd0}; // n=64 bit14
    tbl[7]  = '{0, 0, 16'h0000, 448, 1, 0, 1, 0, 0, 0, 16'd0}; // n=512 right slot
    tbl[8]  = '{0, 0, 16'h0000, 544, 1, 0, 0, 0, 1, 1, 16'd1}; // n=1056 underrun
    tbl[9]  = '{0, 0, 16'h0000,  32, 1, 0, 0, 1, 0, 0, 16'd1}; // n=1088 repeated bit
    tbl[10] = '{0, 0, 16'h0000, 992, 1, 0, 0, 0, 1, 1, 16'd2}; // n=2080 second underrun

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; vld = tbl[i].vld; din = tbl[i].data;
      for (int c = 0; c < tbl[i].cyc; c++) step();
      check($sformatf("vec%0d", i), {9'd0, rdy, bclk, lrck, dat, fl, ur, ucnt},
            {9'd0, tbl[i].e_rdy, tbl[i].e_bclk, tbl[i].e_lrck, tbl[i].e_dat,
             tbl[i].e_fl, tbl[i].e_ur, tbl[i].e_cnt});
    end

    // Back-to-back producer: second sample waits for the first load.
    rst = 1; step(); rst = 0;
    vld = 1; din = 16'h1234; step();
    check("s4_rdy_after_accept", rdy, 1'b0);
    din = 16'h8001;
    while (n < 31) begin step(); check("s4_rdy_wait", rdy, 1'b0); end
    step();
    check("s4_rdy_after_load", rdy, 1'b1);
    check("s4_load_msb", {fl, ur, dat}, 3'b100);
    step();
    check("s4_second_accepted", rdy, 1'b0);
    vld = 0;
    run_to(FR + 2 * H);
    check("s4_8001_msb", {fl, ur, dat, rdy}, 4'b1011);
    vld = 1; din = 16'h7FFF; step(); vld = 0;
    run_to(2 * FR);
    check("s4_slot0_lsb", dat, 1'b1);
    run_to(2 * FR + 2 * H);
    check("s4_next_msb", {fl, ur, dat}, 3'b100);

    // Valid arriving in a load cycle with the register empty.
    rst = 1; step(); rst = 0;
    run_to(2 * H - 1);
    vld = 1; din = 16'hABCD; step(); vld = 0;
    check("s6_load_cycle", {fl, ur, rdy, ucnt}, {3'b110, 16'd1});
    run_to(FR + 2 * H - 1);
    check("s6_still_full", rdy, 1'b0);
    step();
    check("s6_next_load", {fl, ur, rdy, dat}, 4'b1011);

    // Restart mid-frame during slot 10.
    rst = 1; step(); rst = 0;
    vld = 1; din = 16'h5000; step(); vld = 0;
    run_to(2 * H * 10 + 5);
    rst = 1; step(); rst = 0;
    check("s5_reset_outputs", {rdy, bclk, lrck, dat, fl, ur, ucnt}, {1'b1, 5'b0, 16'd0});
    vld = 1; din = 16'h5000; step(); vld = 0;
    check("s5_accept", rdy, 1'b0);
    run_to(2 * H);
    check("s5_first_load", {fl, ur, rdy, bclk}, 4'b1010);

    // Random traffic with varying producer rates and occasional restarts.
    for (int blk = 0; blk < 15; blk++) begin
      int rate;
      rate = $urandom_range(0, 100);
      for (int c = 0; c < 1000; c++) begin
        rst = ($urandom_range(0, 2999) == 0);
        vld = ($urandom_range(0, 99) < rate);
        din = 16'($urandom);
        step();
      end
    end
    rst = 0; vld = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
